// File: rtl/dcb_pkg.sv
// Shared types, widths and saturating-increment helpers for the data consuming block.
package dcb_pkg;

  localparam int DATA_W = 8;
  localparam int SUM_W  = 16;
  localparam int CNT_W  = 16;
  localparam int ERR_W  = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

  typedef enum logic [0:0] {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } dcb_state_e;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    if (v == ERR_MAX) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/dcb_fifo.sv
// Synchronous power-of-two FIFO; exports both the registered level and its next-state value.
module dcb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] level_nxt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push_s, pop_s;

  assign full      = (level_q == LVL_FULL);
  assign empty     = (level_q == {LW{1'b0}});
  assign push_s    = push && !full;
  assign pop_s     = pop && !empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign level_nxt = level_d;

  // Next-state storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // FIFO state registers; reset discards any buffered data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: {DATA_W{1'b0}}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/data_consuming_block.sv
// Byte-stream sink: FIFO, rate-limited drain, checksum and word count.
// Sequence checking (FSM, seq_err, err_count) is built only when DCB_SEQ_CHECK_EN is defined.
module data_consuming_block
  import dcb_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DRAIN_DIV = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   drain_en,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [SUM_W-1:0]       checksum,
  output logic [CNT_W-1:0]       word_count,
  output logic                   seq_err,
  output logic [ERR_W-1:0]       err_count
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(DRAIN_DIV - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic              ready_q, ready_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [SUM_W-1:0]  checksum_q, checksum_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic              push_s, pop_s;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] pop_byte;
  logic [LW-1:0]     fifo_level, fifo_level_nxt;

  assign push_s = valid_in && ready_q && !fifo_full;

  dcb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .wdata     (data_in),
    .rdata     (pop_byte),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .level_nxt (fifo_level_nxt)
  );

  // Drain timer: advances only while draining a non-empty FIFO, pops on its last count.
  always_comb begin
    timer_d = timer_q;
    pop_s   = 1'b0;
    if (drain_en && !fifo_empty) begin
      if (timer_q == T_LAST) begin
        timer_d = {TW{1'b0}};
        pop_s   = 1'b1;
      end else begin
        timer_d = timer_q + T_ONE;
        pop_s   = 1'b0;
      end
    end else begin
      timer_d = timer_q;
      pop_s   = 1'b0;
    end
  end

  // Accumulators and ready; ready looks at the post-edge level so it never admits a push into a full FIFO.
  always_comb begin
    checksum_d   = checksum_q;
    word_count_d = word_count_q;
    ready_d      = (fifo_level_nxt != LVL_FULL);
    if (pop_s) begin
      checksum_d   = checksum_q + {{(SUM_W-DATA_W){1'b0}}, pop_byte};
      word_count_d = sat_inc_cnt(word_count_q);
    end else begin
      checksum_d   = checksum_q;
      word_count_d = word_count_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q      <= 1'b0;
      timer_q      <= {TW{1'b0}};
      checksum_q   <= {SUM_W{1'b0}};
      word_count_q <= {CNT_W{1'b0}};
    end else begin
      ready_q      <= ready_d;
      timer_q      <= timer_d;
      checksum_q   <= checksum_d;
      word_count_q <= word_count_d;
    end
  end

  assign ready_out  = ready_q;
  assign fill_level = fifo_level;
  assign checksum   = checksum_q;
  assign word_count = word_count_q;

`ifdef DCB_SEQ_CHECK_EN
  dcb_state_e        state_q, state_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic              seq_err_q, seq_err_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  // Sequence tracker: the first byte after reset seeds the expectation, later mismatches resync.
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    seq_err_d   = seq_err_q;
    err_count_d = err_count_q;
    if (pop_s) begin
      expected_d = pop_byte + 8'd1;
      case (state_q)
        SYNC: begin
          state_d = TRACK;
        end
        TRACK: begin
          state_d = TRACK;
          if (pop_byte != expected_q) begin
            seq_err_d   = 1'b1;
            err_count_d = sat_inc_err(err_count_q);
          end else begin
            seq_err_d   = seq_err_q;
            err_count_d = err_count_q;
          end
        end
        default: begin
          state_d = SYNC;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Sequence-check registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SYNC;
      expected_q  <= {DATA_W{1'b0}};
      seq_err_q   <= 1'b0;
      err_count_q <= {ERR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      seq_err_q   <= seq_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign seq_err   = seq_err_q;
  assign err_count = err_count_q;
`else
  assign seq_err   = 1'b0;
  assign err_count = {ERR_W{1'b0}};
`endif

endmodule

// File: tb/tb_data_consuming_block.sv
// Randomised and directed bench for data_consuming_block; two instances (DRAIN_DIV 3 and 1)
// share stimulus and are each compared every cycle against a queue-based reference model.
module tb_data_consuming_block;

  localparam int DEPTH = 4;
  localparam int NI    = 2;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       valid_in = 1'b0;
  logic       drain_en = 1'b0;
  logic [7:0] data_in  = 8'd0;

  logic        rdy3, rdy1, se3, se1;
  logic [2:0]  lvl3, lvl1;
  logic [15:0] sum3, sum1, wc3, wc1;
  logic [7:0]  ec3, ec1;

  always #5 clk = ~clk;

  data_consuming_block #(.DEPTH(DEPTH), .DRAIN_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(rdy3), .data_in(data_in),
    .drain_en(drain_en), .fill_level(lvl3), .checksum(sum3), .word_count(wc3),
    .seq_err(se3), .err_count(ec3)
  );

  data_consuming_block #(.DEPTH(DEPTH), .DRAIN_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(rdy1), .data_in(data_in),
    .drain_en(drain_en), .fill_level(lvl1), .checksum(sum1), .word_count(wc1),
    .seq_err(se1), .err_count(ec1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: index 0 models DRAIN_DIV=3, index 1 models DRAIN_DIV=1.
  int         div_of [NI] = '{3, 1};
  logic [7:0] mq     [NI][$];
  int         m_timer[NI] = '{0, 0};
  bit         m_ready[NI] = '{1'b0, 1'b0};
  int         m_sum  [NI] = '{0, 0};
  int         m_cnt  [NI] = '{0, 0};
  bit         m_sync [NI] = '{1'b0, 1'b0};
  bit         m_err  [NI] = '{1'b0, 1'b0};
  int         m_exp  [NI] = '{0, 0};
  int         m_ecnt [NI] = '{0, 0};
  int         mb;
  bit         m_push, m_pop;

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        mq[i].delete();
        m_timer[i] = 0; m_ready[i] = 1'b0; m_sum[i] = 0; m_cnt[i] = 0;
        m_sync[i] = 1'b0; m_err[i] = 1'b0; m_exp[i] = 0; m_ecnt[i] = 0;
      end else begin
        m_push = valid_in && m_ready[i];
        m_pop  = drain_en && (mq[i].size() > 0) && (m_timer[i] == div_of[i] - 1);
        if (drain_en && mq[i].size() > 0) m_timer[i] = (m_timer[i] + 1) % div_of[i];
        if (m_pop) begin
          mb = int'(mq[i].pop_front());
          m_sum[i] = (m_sum[i] + mb) % 65536;
          if (m_cnt[i] < 65535) m_cnt[i]++;
          if (m_sync[i] && mb != m_exp[i]) begin
            m_err[i] = 1'b1;
            if (m_ecnt[i] < 255) m_ecnt[i]++;
          end
          m_sync[i] = 1'b1;
          m_exp[i]  = (mb + 1) % 256;
        end
        if (m_push) mq[i].push_back(data_in);
        m_ready[i] = (mq[i].size() < DEPTH);
      end
    end
  end

  function automatic int exp_se(input int i);
`ifdef DCB_SEQ_CHECK_EN
    return int'(m_err[i]);
`else
    return 0;
`endif
  endfunction

  function automatic int exp_ec(input int i);
`ifdef DCB_SEQ_CHECK_EN
    return m_ecnt[i];
`else
    return 0;
`endif
  endfunction

  task automatic cmp_inst(input int i, input logic rdy, input logic [2:0] lvl, input logic [15:0] sum,
                          input logic [15:0] wc, input logic se, input logic [7:0] ec);
    check_val($sformatf("ready_out[%0d]", i), 32'(rdy), 32'(m_ready[i]));
    check_val($sformatf("fill_level[%0d]", i), 32'(lvl), 32'(mq[i].size()));
    check_val($sformatf("checksum[%0d]", i), 32'(sum), 32'(m_sum[i]));
    check_val($sformatf("word_count[%0d]", i), 32'(wc), 32'(m_cnt[i]));
    check_val($sformatf("seq_err[%0d]", i), 32'(se), 32'(exp_se(i)));
    check_val($sformatf("err_count[%0d]", i), 32'(ec), 32'(exp_ec(i)));
  endtask

  // Cycle-by-cycle model comparison, sampled on the inactive edge.
  always @(negedge clk) begin
    cmp_inst(0, rdy3, lvl3, sum3, wc3, se3, ec3);
    cmp_inst(1, rdy1, lvl1, sum1, wc1, se1, ec1);
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rdy"}, 32'({rdy3, rdy1}), 32'd0);
    check_val({tag, "_lvl"}, 32'({lvl3, lvl1}), 32'd0);
    check_val({tag, "_sum"}, 32'(sum3 | sum1), 32'd0);
    check_val({tag, "_wc"},  32'(wc3 | wc1), 32'd0);
    check_val({tag, "_err"}, 32'({se3, se1, ec3, ec1}), 32'd0);
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    drain_en = 1'b0;
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  int         exp_lvl[6] = '{2, 2, 1, 1, 1, 0};
  logic [7:0] wrap_seq[5] = '{8'hFE, 8'hFF, 8'h00, 8'h05, 8'h06};
  int         wrap_sum;
  bit         ready_fell;
  logic [7:0] seqv;

  initial begin
    // Reset and idle
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_val("ready_after_reset", 32'({rdy3, rdy1}), 32'h3);

    // Back-to-back stream on the DRAIN_DIV=1 instance
    drain_en   = 1'b1;
    valid_in   = 1'b1;
    ready_fell = 1'b0;
    for (int k = 0; k < 10; k++) begin
      data_in = 8'(k);
      @(negedge clk);
      if (!rdy1) ready_fell = 1'b1;
    end
    valid_in = 1'b0;
    repeat (4) @(negedge clk);
    check_val("b2b_ready_fell", 32'(ready_fell), 32'd0);
    check_val("b2b_word_count", 32'(wc1), 32'd10);
    check_val("b2b_checksum", 32'(sum1), 32'd45);
    check_val("b2b_seq_err", 32'(se1), 32'd0);

    // Backpressure and full
    do_reset();
    valid_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      data_in = 8'h10 + 8'(k);
      @(negedge clk);
      if (k == 2) check_val("bp_ready_before_full", 32'(rdy1), 32'd1);
      if (k >= 3) check_val("bp_ready_full", 32'(rdy1), 32'd0);
      if (k >= 3) check_val("bp_level_full", 32'(lvl1), 32'd4);
    end
    valid_in = 1'b0;
    drain_en = 1'b1;
    @(negedge clk);
    check_val("bp_ready_after_pop", 32'(rdy1), 32'd1);
    check_val("bp_level_after_pop", 32'(lvl1), 32'd3);
    repeat (6) @(negedge clk);
    check_val("bp_checksum", 32'(sum1), 32'h46);

    // Byte wrap and a sequence break
    do_reset();
    drain_en = 1'b1;
    valid_in = 1'b1;
    wrap_sum = 0;
    for (int k = 0; k < 5; k++) begin
      data_in  = wrap_seq[k];
      wrap_sum = wrap_sum + int'(wrap_seq[k]);
      @(negedge clk);
    end
    valid_in = 1'b0;
    repeat (4) @(negedge clk);
    check_val("wrap_checksum", 32'(sum1), 32'(wrap_sum % 65536));
    check_val("wrap_word_count", 32'(wc1), 32'd5);
`ifdef DCB_SEQ_CHECK_EN
    check_val("wrap_seq_err", 32'(se1), 32'd1);
    check_val("wrap_err_count", 32'(ec1), 32'd1);
`else
    check_val("wrap_seq_err", 32'({se1, ec1}), 32'd0);
`endif

    // Drain rate with DRAIN_DIV=3
    do_reset();
    valid_in = 1'b1;
    data_in  = 8'h30;
    @(negedge clk);
    data_in  = 8'h31;
    @(negedge clk);
    valid_in = 1'b0;
    drain_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val($sformatf("drain_level_%0d", k), 32'(lvl3), 32'(exp_lvl[k]));
    end

    // Mid-operation reset with buffered data and a flagged error
    do_reset();
    drain_en = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h10;
    @(negedge clk);
    data_in  = 8'h20;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (8) @(negedge clk);
    drain_en = 1'b0;
    valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_in = 8'h40 + 8'(k);
      @(negedge clk);
    end
    valid_in = 1'b0;
    check_val("mid_level", 32'(lvl3), 32'd3);
`ifdef DCB_SEQ_CHECK_EN
    check_val("mid_seq_err", 32'(se3), 32'd1);
`endif
    do_reset();
    drain_en = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h77;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (6) @(negedge clk);
    check_val("post_rst_seq_err", 32'(se3), 32'd0);
    check_val("post_rst_word_count", 32'(wc3), 32'd1);
    check_val("post_rst_checksum", 32'(sum3), 32'h77);

    // Randomised traffic, mostly incrementing data with occasional jumps and resets
    seqv = 8'($urandom);
    for (int n = 0; n < 1500; n++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      drain_en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) seqv = 8'($urandom);
      data_in = seqv;
      if (valid_in) seqv = seqv + 8'd1;
      if (n % 500 == 499) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    valid_in = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
